zion_basic_circuit_lib_rr_reg_arbiter: RTL

//   Round-robin arbiter that shares one registered pipeline stage between NUM requesters.

---
 rtl/zion_basic_circuit_lib_rr_reg_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/zion_basic_circuit_lib_rr_reg_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready stage shared by NUM requesters.
// Latency 1 cycle from input transfer to oVld; oRdy drops while the stage is full and iRdy is low.
module zion_basic_circuit_lib_rr_reg_arbiter #(
  parameter int NUM   = 2,
  parameter int WIDTH = 8,
  parameter int ID_W  = ($clog2(NUM) > 0) ? $clog2(NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM-1:0]       iVld,
  input  logic [NUM*WIDTH-1:0] iDat,
  output logic [NUM-1:0]       oRdy,
  output logic                 oVld,
  output logic [WIDTH-1:0]     oDat,
  output logic [ID_W-1:0]      oId,
  input  logic                 iRdy
);

  if (NUM < 1 || NUM > 64 || WIDTH < 1) begin : g_bad_param
`ifdef CHECK_ERR_EXIT
    $fatal(1, "rr_reg_arbiter: illegal parameters NUM=%0d WIDTH=%0d", NUM, WIDTH);
`else
    $error("rr_reg_arbiter: illegal parameters NUM=%0d WIDTH=%0d", NUM, WIDTH);
`endif
  end

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [NUM-1:0]   grant;
  logic [WIDTH-1:0] gnt_dat;
  logic             found;
  logic             free;
  logic             xfer;

  // Two passes: indices at/after ptr first, then the wrapped-around ones below ptr.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_dat = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (!found && iVld[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_id   = ID_W'(i);
        gnt_dat  = iDat[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (!found && iVld[i] && (i < int'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_id   = ID_W'(i);
        gnt_dat  = iDat[i*WIDTH +: WIDTH];
      end
    end
  end

  assign free = !oVld || iRdy;
  // Ready is held off during reset so no requester believes a discarded word was taken.
  assign oRdy = (free && !rst) ? grant : '0;
  assign xfer = found && free && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      oVld <= 1'b0;
      oDat <= '0;
      oId  <= '0;
      ptr  <= '0;
    end else if (xfer) begin
      oVld <= 1'b1;
      oDat <= gnt_dat;
      oId  <= gnt_id;
      ptr  <= (gnt_id == ID_W'(NUM - 1)) ? '0 : gnt_id + ID_W'(1);
    end else if (iRdy) begin
      oVld <= 1'b0;
    end
  end

endmodule
